// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          IMEM_AW_DEF  = 14;

  typedef enum logic [1:0] {
    PC_SEL_RESET,
    PC_SEL_HOLD,
    PC_SEL_BRANCH,
    PC_SEL_SEQ
  } pc_sel_e;

  // Word-aligned redirect target; the low byte-offset bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch PC register plus the prioritised next-PC mux.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  pc_sel_e     sel;

  always_comb begin
    sel = PC_SEL_SEQ;
    if (rst)              sel = PC_SEL_RESET;
    else if (stall)       sel = PC_SEL_HOLD;
    else if (branch_flag) sel = PC_SEL_BRANCH;
  end

  always_comb begin
    pc_d = pc_plus4(pc_q);
    case (sel)
      PC_SEL_RESET:  pc_d = RESET_PC;
      PC_SEL_HOLD:   pc_d = pc_q;
      PC_SEL_BRANCH: pc_d = align_word(branch_addr);
      default:       pc_d = pc_plus4(pc_q);
    endcase
  end

  // Hold is already folded into pc_d, so the register loads every edge.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc_f_o    = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and delay-slot redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_flag,
  input  logic [31:0]        branch_addr,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_inst,
  output logic               id_valid,
  output logic [31:0]        fetch_count
);

  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic [31:0] fetch_count_q;
  logic        unused_pc_bits;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .pc_f_o      (pc_f),
    .pc_next_o   (pc_next)
  );

  // Upper PC bits alias modulo the memory depth; only the word index is sent.
  assign imem_addr      = pc_next[IMEM_AW+1:2];
  assign imem_en        = rst | ~stall;
  assign unused_pc_bits = ^{pc_next[31:IMEM_AW+2], pc_next[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q       <= ZERO_WORD;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
      fetch_count_q <= ZERO_WORD;
    end else if (!stall) begin
      id_pc_q       <= pc_f;
      id_inst_q     <= imem_rdata;
      id_valid_q    <= 1'b1;
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: default instance plus a small wrapping-PC instance.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_flag;
  logic [31:0] branch_addr;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc, id_inst, fetch_count;
  logic        id_valid;

  logic        rst2;
  logic        imem2_en;
  logic [3:0]  imem2_addr;
  logic [31:0] imem2_rdata;
  logic [31:0] id2_pc, id2_inst, fetch2_count;
  logic        id2_valid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_addr(branch_addr), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(4)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .branch_flag(1'b0),
    .branch_addr(32'h0), .imem_en(imem2_en), .imem_addr(imem2_addr),
    .imem_rdata(imem2_rdata), .id_pc(id2_pc), .id_inst(id2_inst),
    .id_valid(id2_valid), .fetch_count(fetch2_count)
  );

  function automatic logic [31:0] memw(input logic [31:0] widx);
    if (widx == 32'd0) return 32'h2008_0005;
    if (widx == 32'd1) return 32'h2009_0003;
    return 32'hA000_0000 | widx;
  endfunction

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= memw({18'b0, imem_addr});
    if (imem2_en) imem2_rdata <= memw({28'b0, imem2_addr});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
    step(); step();

    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_en", {31'b0, imem_en}, 32'd1);
    chk("rst_addr", {18'b0, imem_addr}, 32'd0);

    // Reset release and sequential fetch
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("seq_addr", {18'b0, imem_addr}, k + 1);
      step();
      chk("seq_pc", id_pc, 4 * k);
      chk("seq_inst", id_inst, memw(k));
      chk("seq_valid", {31'b0, id_valid}, 32'd1);
      chk("seq_count", fetch_count, k + 1);
      if (k == 0) chk("first_inst", id_inst, 32'h2008_0005);
      if (k == 1) begin
        chk("second_inst", id_inst, 32'h2009_0003);
        chk("count_two", fetch_count, 32'd2);
      end
    end

    // Branch with delay slot, unaligned target
    do_reset();
    step(); step(); step();
    chk("br_pre_pc", id_pc, 32'h8);
    branch_flag = 1'b1; branch_addr = 32'h43;
    #1;
    chk("br_addr", {18'b0, imem_addr}, 32'h10);
    step();
    branch_flag = 1'b0;
    chk("br_slot_pc", id_pc, 32'hC);
    chk("br_slot_inst", id_inst, memw(3));
    step();
    chk("br_tgt_pc", id_pc, 32'h40);
    chk("br_tgt_inst", id_inst, memw(16));
    step();
    chk("br_next_pc", id_pc, 32'h44);

    // Stall with a branch request that must be ignored
    do_reset();
    repeat (5) step();
    chk("st_pre_pc", id_pc, 32'h10);
    stall = 1'b1; branch_flag = 1'b1; branch_addr = 32'h80;
    #1;
    chk("st_en", {31'b0, imem_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_pc", id_pc, 32'h10);
      chk("st_inst", id_inst, memw(4));
      chk("st_count", fetch_count, 32'd5);
      chk("st_addr", {18'b0, imem_addr}, 32'd5);
    end
    stall = 1'b0; branch_flag = 1'b0;
    step();
    chk("st_rel_pc", id_pc, 32'h14);
    chk("st_rel_inst", id_inst, memw(5));
    chk("st_rel_count", fetch_count, 32'd6);
    step();
    chk("st_rel2_pc", id_pc, 32'h18);
    chk("st_rel2_inst", id_inst, memw(6));

    // Reset mid-stream while stalled
    branch_flag = 1'b1; branch_addr = 32'h100;
    step();
    branch_flag = 1'b0;
    step();
    chk("mid_pre_pc", id_pc, 32'h100);
    stall = 1'b1; rst = 1'b1;
    step();
    chk("mid_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_inst", id_inst, 32'h0);
    chk("mid_count", fetch_count, 32'd0);
    rst = 1'b0; stall = 1'b0;
    step();
    chk("mid_rel_pc", id_pc, 32'h0);
    chk("mid_rel_inst", id_inst, 32'h2008_0005);
    chk("mid_rel_valid", {31'b0, id_valid}, 32'd1);
    chk("mid_rel_count", fetch_count, 32'd1);

    // PC wrap with a small aliased memory
    chk("wr_rst_addr", {28'b0, imem2_addr}, 32'd14);
    rst2 = 1'b0;
    #1;
    chk("wr_rel_addr", {28'b0, imem2_addr}, 32'd15);
    step();
    chk("wr_pc0", id2_pc, 32'hFFFF_FFF8);
    chk("wr_inst0", id2_inst, memw(14));
    chk("wr_addr0", {28'b0, imem2_addr}, 32'd0);
    step();
    chk("wr_pc1", id2_pc, 32'hFFFF_FFFC);
    chk("wr_inst1", id2_inst, memw(15));
    chk("wr_addr1", {28'b0, imem2_addr}, 32'd1);
    step();
    chk("wr_pc2", id2_pc, 32'h0);
    chk("wr_inst2", id2_inst, 32'h2008_0005);
    step();
    chk("wr_pc3", id2_pc, 32'h4);
    chk("wr_inst3", id2_inst, 32'h2009_0003);
    chk("wr_count", fetch2_count, 32'd4);
    chk("wr_valid", {31'b0, id2_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
